// File: rtl/warmboot_ctrl.sv
// Reboot sequencer in front of SB_WARMBOOT: arbitrates DFU / long-press / CSR requests,
// then holds the USB detach, presents S1:S0 with setup margin and finally raises BOOT.
//
// state  | meaning
// IDLE   | waiting for a request, outputs low, o_image holds last target
// DETACH | USB pull-up released, counting down the detach interval
// SETUP  | S lines stable with BOOT low, counting down the setup margin
// BOOT   | BOOT high, held until reconfiguration or reset
module warmboot_ctrl #(
    parameter int DETACH_CYCLES    = 48000,
    parameter int SETUP_CYCLES     = 8,
    parameter int LONGPRESS_CYCLES = 96000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_dfu_detach,
    input  logic       i_button,
    input  logic       i_sw_req,
    input  logic [1:0] i_sw_image,
    output logic       o_busy,
    output logic       o_usb_detach,
    output logic [1:0] o_image,
    output logic [1:0] o_wb_s,
    output logic       o_wb_boot
);

    localparam int MAX_CYC = (DETACH_CYCLES > SETUP_CYCLES) ? DETACH_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int LP_W    = (LONGPRESS_CYCLES > 1) ? $clog2(LONGPRESS_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DETACH_LOAD = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [LP_W-1:0]  LP_LAST     = LP_W'(LONGPRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETACH = 2'd1,
        SETUP  = 2'd2,
        BOOT   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       image, image_nxt;
    logic [LP_W-1:0]  lp_cnt;
    logic             lp_done;
    logic             lp_fire;
    logic             req;
    logic [1:0]       req_image;

    // Long-press: lp_done blocks repeat triggers until the button is released.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lp_cnt  <= '0;
            lp_done <= 1'b0;
            lp_fire <= 1'b0;
        end else if (!i_button) begin
            lp_cnt  <= '0;
            lp_done <= 1'b0;
            lp_fire <= 1'b0;
        end else begin
            if (lp_cnt != LP_LAST) begin
                lp_cnt <= lp_cnt + LP_W'(1);
            end
            lp_fire <= (lp_cnt == LP_LAST) && !lp_done;
            if (lp_cnt == LP_LAST) begin
                lp_done <= 1'b1;
            end
        end
    end

    always_comb begin
        req = i_dfu_detach || lp_fire || i_sw_req;
        if (i_dfu_detach || lp_fire) begin
            req_image = 2'd1;
        end else begin
            req_image = i_sw_image;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
            image <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            image <= image_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        image_nxt = image;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = DETACH;
                    cnt_nxt   = DETACH_LOAD;
                    image_nxt = req_image;
                end
            end
            DETACH: begin
                if (cnt == '0) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = BOOT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            BOOT: begin
                state_nxt = BOOT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy       = (state != IDLE);
        o_usb_detach = (state != IDLE);
        o_wb_boot    = (state == BOOT);
        o_image      = image;
        o_wb_s       = image;
    end

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed bench for warmboot_ctrl with short detach/setup/long-press intervals.
module tb_warmboot_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_dfu_detach;
    logic       i_button;
    logic       i_sw_req;
    logic [1:0] i_sw_image;
    logic       o_busy;
    logic       o_usb_detach;
    logic [1:0] o_image;
    logic [1:0] o_wb_s;
    logic       o_wb_boot;

    int passed = 0;
    int total  = 0;

    warmboot_ctrl #(
        .DETACH_CYCLES   (10),
        .SETUP_CYCLES    (4),
        .LONGPRESS_CYCLES(20)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_dfu_detach(i_dfu_detach),
        .i_button    (i_button),
        .i_sw_req    (i_sw_req),
        .i_sw_image  (i_sw_image),
        .o_busy      (o_busy),
        .o_usb_detach(o_usb_detach),
        .o_image     (o_image),
        .o_wb_s      (o_wb_s),
        .o_wb_boot   (o_wb_boot)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"},   {1'b0, o_busy},       2'd0);
        check({tag, ".detach"}, {1'b0, o_usb_detach}, 2'd0);
        check({tag, ".image"},  o_image,              2'd0);
        check({tag, ".wb_s"},   o_wb_s,               2'd0);
        check({tag, ".boot"},   {1'b0, o_wb_boot},    2'd0);
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    // Entered just after the request edge; BOOT must rise 14 edges later.
    task automatic boot_seq(input logic [1:0] img, input bit inject, input string tag);
        check({tag, ".busy0"},   {1'b0, o_busy},       2'd1);
        check({tag, ".detach0"}, {1'b0, o_usb_detach}, 2'd1);
        check({tag, ".wb_s0"},   o_wb_s,               img);
        check({tag, ".boot0"},   {1'b0, o_wb_boot},    2'd0);
        for (int t = 1; t < 14; t++) begin
            if (inject && t == 3) begin
                i_sw_req   = 1'b1;
                i_sw_image = 2'd0;
            end
            tick();
            i_sw_req = 1'b0;
            check({tag, ".boot_lo"}, {1'b0, o_wb_boot},    2'd0);
            check({tag, ".detach"},  {1'b0, o_usb_detach}, 2'd1);
            check({tag, ".wb_s"},    o_wb_s,               img);
        end
        tick();
        check({tag, ".boot_hi"}, {1'b0, o_wb_boot}, 2'd1);
        check({tag, ".busy"},    {1'b0, o_busy},    2'd1);
        check({tag, ".image"},   o_image,           img);
        check({tag, ".wb_s_b"},  o_wb_s,            img);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_dfu_detach = 1'b0;
        i_button     = 1'b0;
        i_sw_req     = 1'b0;
        i_sw_image   = 2'd0;
        tick();
        tick();
        i_reset = 1'b0;
        check_idle("reset");
        tick();
        check_idle("idle");

        // software request, image 2
        i_sw_req   = 1'b1;
        i_sw_image = 2'd2;
        tick();
        i_sw_req = 1'b0;
        boot_seq(2'd2, 1'b0, "sw2");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sw2.boot_held", {1'b0, o_wb_boot}, 2'd1);
        end
        pulse_reset();
        check_idle("rst_boot");

        // DFU beats simultaneous software request; a request in DETACH is dropped
        i_dfu_detach = 1'b1;
        i_sw_req     = 1'b1;
        i_sw_image   = 2'd2;
        tick();
        i_dfu_detach = 1'b0;
        i_sw_req     = 1'b0;
        check("prio.image", o_image, 2'd1);
        boot_seq(2'd1, 1'b1, "dfu");
        pulse_reset();
        check_idle("rst_dfu");

        // reset mid-DETACH, then image 3
        i_sw_req   = 1'b1;
        i_sw_image = 2'd2;
        tick();
        i_sw_req = 1'b0;
        tick();
        tick();
        check("mid.busy", {1'b0, o_busy}, 2'd1);
        pulse_reset();
        check_idle("rst_det");
        i_sw_req   = 1'b1;
        i_sw_image = 2'd3;
        tick();
        i_sw_req = 1'b0;
        boot_seq(2'd3, 1'b0, "sw3");
        pulse_reset();
        check_idle("rst_sw3");

        // long press one cycle short
        i_button = 1'b1;
        for (int k = 0; k < 19; k++) tick();
        i_button = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("lp19.busy", {1'b0, o_busy}, 2'd0);
        end

        // long press held 25 cycles
        i_button = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("lp25.busy_lo", {1'b0, o_busy}, 2'd0);
        end
        tick();
        check("lp25.busy_hi", {1'b0, o_busy},       2'd1);
        check("lp25.image",   o_image,              2'd1);
        check("lp25.detach",  {1'b0, o_usb_detach}, 2'd1);
        for (int k = 0; k < 4; k++) tick();
        i_button = 1'b0;
        tick();
        check("lp25.wb_s", o_wb_s, 2'd1);
        pulse_reset();
        check_idle("rst_lp");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
